// File: rtl/lz77_decoder_pkg.sv
// Shared definitions for the LZ77 decoder: address/length width helper,
// match-length limits, default geometry and the decoder state encoding.
package lz77_decoder_pkg;

    // Smallest width able to address 'value' distinct items (ceil(log2)).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int DATA_WIDTH_DEF       = 8;
    localparam int DICT_DEPTH_DEF       = 2048;
    localparam int LOOK_AHEAD_DEPTH_DEF = 258;

    localparam int MIN_MATCH_LEN = 1;
    localparam int MAX_MATCH_LEN = LOOK_AHEAD_DEPTH_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LIT   = 2'd1,
        ST_PRIME = 2'd2,
        ST_COPY  = 2'd3
    } dec_state_t;

endpackage

// File: rtl/lz77_history_ram.sv
// History window for the LZ77 decoder.
// One write port, one synchronous read port, single clock. Write-first: a
// read of the address being written in the same cycle returns the new byte,
// which is what lets a distance-1 copy replicate the byte just emitted.
// Ports:
//   clk          clock
//   we/waddr/wdata   write port
//   raddr        read address, data appears on rdata the next cycle
//   rdata        registered read data
module lz77_history_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 token decoder: expands literal / back-reference tokens into a byte
// stream, one byte per handshake, keeping a circular history window.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   tok_valid/tok_ready        token handshake
//   tok_is_match, tok_distance, tok_length, tok_literal, tok_last   token fields
//   out_valid/out_ready        output byte handshake
//   out_data, out_last         decoded byte, last byte of the final token
//   protocol_err               sticky illegal-token flag
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no byte held; waiting for a token
// ST_LIT   | literal byte presented on the output
// ST_PRIME | history read of the first copy byte in flight
// ST_COPY  | copy bytes streamed from history, one per handshake
module lz77_decoder
    import lz77_decoder_pkg::*;
#(
    parameter int DATA_WIDTH            = DATA_WIDTH_DEF,
    parameter int DICTIONARY_DEPTH      = DICT_DEPTH_DEF,
    parameter int DICTIONARY_DEPTH_LOG  = clogb2(DICTIONARY_DEPTH),
    parameter int LOOK_AHEAD_BUFF_DEPTH = LOOK_AHEAD_DEPTH_DEF,
    parameter int CNT_WIDTH             = clogb2(LOOK_AHEAD_BUFF_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tok_valid,
    output logic                            tok_ready,
    input  logic                            tok_is_match,
    input  logic [DICTIONARY_DEPTH_LOG-1:0] tok_distance,
    input  logic [CNT_WIDTH-1:0]            tok_length,
    input  logic [DATA_WIDTH-1:0]           tok_literal,
    input  logic                            tok_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_last,
    output logic                            protocol_err
);

    localparam int AW = DICTIONARY_DEPTH_LOG;
    localparam logic [AW:0] HIST_FULL = (AW+1)'(DICTIONARY_DEPTH);

    dec_state_t state, state_nxt;

    logic [AW-1:0]         wr_ptr, wr_ptr_inc;
    logic [AW-1:0]         rd_ptr, rd_ptr_nxt, ram_raddr;
    logic [AW:0]           hist_count, hist_count_inc;
    logic [CNT_WIDTH-1:0]  remaining, remaining_nxt;
    logic                  last_q, last_nxt;
    logic [DATA_WIDTH-1:0] lit_q, lit_nxt;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  out_hs, tok_acc, tok_bad;

    assign out_valid = (state == ST_LIT) || (state == ST_COPY);
    assign out_data  = (state == ST_COPY) ? ram_rdata : lit_q;
    assign out_last  = last_q && ((state == ST_LIT) ||
                                  ((state == ST_COPY) && (remaining == CNT_WIDTH'(1))));
    assign out_hs    = out_valid && out_ready;

    // A literal being drained this cycle frees the output stage, so a new
    // token may be taken in ST_LIT as well; this keeps literals at 1 byte/cycle.
    assign tok_ready = !rst && ((state == ST_IDLE) || ((state == ST_LIT) && out_ready));
    assign tok_acc   = tok_valid && tok_ready;

    // Pointer and count as they will stand after this cycle's output write;
    // a match accepted while its predecessor literal drains must see it.
    assign wr_ptr_inc     = out_hs ? wr_ptr + AW'(1) : wr_ptr;
    assign hist_count_inc = (out_hs && (hist_count != HIST_FULL)) ? hist_count + (AW+1)'(1)
                                                                  : hist_count;

    assign tok_bad = tok_is_match &&
                     ((tok_length < CNT_WIDTH'(MIN_MATCH_LEN)) ||
                      (tok_distance == '0) ||
                      ({1'b0, tok_distance} > hist_count_inc));

    always_comb begin
        state_nxt     = state;
        rd_ptr_nxt    = rd_ptr;
        remaining_nxt = remaining;
        last_nxt      = last_q;
        lit_nxt       = lit_q;
        ram_raddr     = rd_ptr;
        case (state)
            ST_IDLE, ST_LIT: begin
                if ((state == ST_LIT) && out_hs) begin
                    state_nxt = ST_IDLE;
                end
                if (tok_acc) begin
                    last_nxt = tok_last;
                    if (!tok_is_match) begin
                        lit_nxt   = tok_literal;
                        state_nxt = ST_LIT;
                    end else if (tok_length != '0) begin
                        rd_ptr_nxt    = wr_ptr_inc - tok_distance;
                        remaining_nxt = tok_length;
                        state_nxt     = ST_PRIME;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_PRIME: begin
                state_nxt = ST_COPY;
            end
            ST_COPY: begin
                // On a stall the same address is re-read so out_data holds.
                if (out_hs) begin
                    remaining_nxt = remaining - CNT_WIDTH'(1);
                    rd_ptr_nxt    = rd_ptr + AW'(1);
                    ram_raddr     = rd_ptr_nxt;
                    if (remaining == CNT_WIDTH'(1)) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            hist_count   <= '0;
            remaining    <= '0;
            last_q       <= 1'b0;
            lit_q        <= '0;
            protocol_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_inc;
            rd_ptr     <= rd_ptr_nxt;
            hist_count <= hist_count_inc;
            remaining  <= remaining_nxt;
            last_q     <= last_nxt;
            lit_q      <= lit_nxt;
            if (tok_acc && tok_bad) begin
                protocol_err <= 1'b1;
            end
        end
    end

    lz77_history_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DICTIONARY_DEPTH),
        .ADDR_WIDTH (AW)
    ) u_hist (
        .clk   (clk),
        .we    (out_hs && !rst),
        .waddr (wr_ptr),
        .wdata (out_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_lz77_decoder.sv
module tb_lz77_decoder;

    localparam int D  = 2048;
    localparam int AW = 11;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tok_valid = 1'b0;
    logic          tok_ready;
    logic          tok_is_match = 1'b0;
    logic [AW-1:0] tok_distance = '0;
    logic [CW-1:0] tok_length = '0;
    logic [7:0]    tok_literal = '0;
    logic          tok_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    out_data;
    logic          out_last;
    logic          protocol_err;

    always #5 clk = ~clk;

    lz77_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_is_match (tok_is_match),
        .tok_distance (tok_distance),
        .tok_length   (tok_length),
        .tok_literal  (tok_literal),
        .tok_last     (tok_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .protocol_err (protocol_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a plain byte history plus the expected output stream.
    logic [7:0] m_hist [D];
    int         m_wp  = 0;
    int         m_cnt = 0;
    bit         m_err = 0;
    logic [7:0] exp_q[$];
    bit         exp_last_q[$];
    logic [7:0] got_q[$];
    bit         stall_mode = 0;

    function automatic void push_byte(input logic [7:0] b, input bit l);
        exp_q.push_back(b);
        exp_last_q.push_back(l);
        m_hist[m_wp] = b;
        m_wp = (m_wp + 1) % D;
        if (m_cnt < D) m_cnt++;
    endfunction

    function automatic void model_token(input bit is_m, input int d, input int len,
                                        input logic [7:0] lit, input bit last);
        if (!is_m) begin
            push_byte(lit, last);
        end else begin
            if (len == 0 || d == 0 || d > m_cnt) m_err = 1;
            for (int i = 0; i < len; i++)
                push_byte(m_hist[(m_wp - d) & (D - 1)], last && (i == len - 1));
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_tok(input bit is_m, input int d, input int len,
                            input logic [7:0] lit, input bit last);
        int waitc;
        waitc        = 0;
        tok_is_match = is_m;
        tok_distance = AW'(d);
        tok_length   = CW'(len);
        tok_literal  = lit;
        tok_last     = last;
        tok_valid    = 1'b1;
        @(negedge clk);
        while (!tok_ready && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 2000) chk("tok_accept_timeout", 1, 0);
        else model_token(is_m, d, len, lit, last);
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && c < 5000) begin
            @(negedge clk);
            c++;
        end
        chk("drain_in_time", (c < 5000), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        exp_last_q.delete();
        m_wp  = 0;
        m_cnt = 0;
        m_err = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_stream_15();
        send_tok(0, 0, 0, "a", 0);
        send_tok(0, 0, 0, "a", 0);
        send_tok(0, 0, 0, "c", 0);
        send_tok(1, 3, 4, 0, 0);
        send_tok(0, 0, 0, "b", 0);
        send_tok(1, 3, 3, 0, 0);
        send_tok(0, 0, 0, "a", 0);
        send_tok(1, 1, 2, 0, 0);
        send_tok(0, 0, 0, "c", 1);
    endtask

    task automatic check_stream_15(input string pfx);
        string s;
        s = "aacaacabcabaaac";
        chk({pfx, "_len"}, got_q.size(), s.len());
        for (int i = 0; i < s.len(); i++)
            if (i < got_q.size()) chk($sformatf("%s_byte%0d", pfx, i), got_q[i], s[i]);
        chk({pfx, "_err"}, protocol_err, 0);
    endtask

    // Output consumer: scoreboard compare, stall stability, ready driving.
    initial begin
        bit         prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [7:0] ed;
        bit         el;
        prev_stall = 0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, prev_data);
                    chk("stall_last", out_last, prev_last);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_byte", 1, 0);
                    end else begin
                        ed = exp_q.pop_front();
                        el = exp_last_q.pop_front();
                        chk("out_data", out_data, ed);
                        chk("out_last", out_last, el);
                    end
                    got_q.push_back(out_data);
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
            @(posedge clk);
            #1;
            out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int n_bad;
        int is_m, d, len;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_protocol_err", protocol_err, 0);
        chk("rst_tok_ready", tok_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Literals abc
        got_q.delete();
        send_tok(0, 0, 0, "a", 0);
        @(negedge clk);
        chk("lit_latency", out_valid, 1);
        @(posedge clk);
        #1;
        send_tok(0, 0, 0, "b", 0);
        send_tok(0, 0, 0, "c", 1);
        wait_drain();
        chk("abc_len", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("abc_0", got_q[0], "a");
            chk("abc_1", got_q[1], "b");
            chk("abc_2", got_q[2], "c");
        end

        // Literal + distance-1 run of 66
        got_q.delete();
        send_tok(0, 0, 0, "a", 0);
        send_tok(1, 1, 66, 0, 1);
        @(negedge clk);
        chk("prime_bubble", out_valid, 0);
        @(negedge clk);
        chk("copy_latency", out_valid, 1);
        @(posedge clk);
        #1;
        wait_drain();
        chk("run_len", got_q.size(), 67);
        n_bad = 0;
        foreach (got_q[i]) if (got_q[i] !== "a") n_bad++;
        chk("run_all_a", n_bad, 0);

        // Mixed stream, no stalls then with stalls
        got_q.delete();
        send_stream_15();
        wait_drain();
        check_stream_15("stream");
        stall_mode = 1;
        got_q.delete();
        send_stream_15();
        wait_drain();
        check_stream_15("stream_stall");
        stall_mode = 0;

        // Window wrap: 2100 literals then distance 2047
        do_reset();
        got_q.delete();
        for (int i = 0; i < 2100; i++) send_tok(0, 0, 0, 8'(i % 256), 0);
        send_tok(1, 2047, 10, 0, 1);
        wait_drain();
        chk("wrap_len", got_q.size(), 2110);
        if (got_q.size() == 2110)
            for (int k = 0; k < 10; k++) chk($sformatf("wrap_b%0d", k), got_q[2100 + k], 53 + k);
        chk("wrap_err", protocol_err, 0);

        // Random legal tokens with random backpressure
        stall_mode = 1;
        for (int t = 0; t < 300; t++) begin
            is_m = (m_cnt > 0) && ($urandom_range(0, 2) != 0);
            if (is_m) begin
                d   = $urandom_range(1, (m_cnt < D - 1) ? m_cnt : D - 1);
                len = ($urandom_range(0, 15) == 0) ? 258 : $urandom_range(1, 16);
                send_tok(1, d, len, 0, t == 299);
            end else begin
                send_tok(0, 0, 0, 8'($urandom_range(0, 255)), t == 299);
            end
        end
        wait_drain();
        chk("rand_err", protocol_err, 0);
        stall_mode = 0;

        // Illegal distance, sticky until reset
        do_reset();
        send_tok(0, 0, 0, "x", 0);
        send_tok(0, 0, 0, "y", 0);
        send_tok(1, 5, 3, 0, 0);
        @(negedge clk);
        chk("err_far_dist", protocol_err, 1);
        @(posedge clk);
        #1;
        wait_drain();
        send_tok(0, 0, 0, "q", 1);
        wait_drain();
        chk("err_sticky", protocol_err, 1);
        do_reset();
        @(negedge clk);
        chk("err_cleared", protocol_err, 0);
        @(posedge clk);
        #1;
        // Zero-length match: consumed, no bytes
        got_q.delete();
        send_tok(0, 0, 0, "r", 0);
        send_tok(1, 1, 0, 0, 0);
        wait_drain();
        chk("err_zero_len", protocol_err, 1);
        chk("zero_len_bytes", got_q.size(), 1);

        // Reset in the middle of a copy
        do_reset();
        send_tok(0, 0, 0, "k", 0);
        send_tok(1, 1, 100, 0, 1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_last_q.delete();
        m_wp  = 0;
        m_cnt = 0;
        m_err = 0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", tok_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        send_tok(0, 0, 0, "z", 1);
        wait_drain();
        chk("post_rst_len", got_q.size(), 1);
        if (got_q.size() == 1) chk("post_rst_byte", got_q[0], "z");
        chk("post_rst_err", protocol_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
